// File: rtl/fpnew_special_encoder.sv
// fpnew_special_encoder: pipelined generator of canonical IEEE-754 special and boundary encodings.
// Optional macro FPNEW_SPECIAL_ENC_INFO_EN adds a registered classification output info_o.

package fpnew_special_encoder_pkg;
  // Format indices follow fpnew: 0 FP32, 1 FP64, 2 FP16, 3 FP8, 4 FP16ALT.
  function automatic int unsigned exp_bits(int unsigned fmt);
    case (fmt)
      1:       return 11;
      2, 3:    return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(int unsigned fmt);
    case (fmt)
      1:       return 52;
      2:       return 10;
      3:       return 2;
      4:       return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(int unsigned fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

  typedef struct packed {
    logic is_normal;
    logic is_subnormal;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_signalling;
    logic is_quiet;
    logic is_boxed;
  } fp_info_t;
endpackage

module fpnew_special_encoder
  import fpnew_special_encoder_pkg::*;
#(
  parameter int unsigned FpFormat    = 0,
  parameter int unsigned OutWidth    = fp_width(FpFormat),
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth    = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [2:0]          class_i,
  input  logic                sign_i,
  input  logic                box_i,
  input  logic [TagWidth-1:0] tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [OutWidth-1:0] result_o,
`ifdef FPNEW_SPECIAL_ENC_INFO_EN
  output fp_info_t            info_o,
`endif
  output logic [TagWidth-1:0] tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o
);

  localparam int unsigned E     = exp_bits(FpFormat);
  localparam int unsigned M     = man_bits(FpFormat);
  localparam int unsigned WIDTH = 1 + E + M;

  localparam logic [2:0] CLS_ZERO     = 3'd0;
  localparam logic [2:0] CLS_INF      = 3'd1;
  localparam logic [2:0] CLS_QNAN     = 3'd2;
  localparam logic [2:0] CLS_SNAN     = 3'd3;
  localparam logic [2:0] CLS_MAX_NORM = 3'd4;
  localparam logic [2:0] CLS_MIN_NORM = 3'd5;
  localparam logic [2:0] CLS_MIN_SUB  = 3'd6;
  localparam logic [2:0] CLS_ONE      = 3'd7;

  if (OutWidth < WIDTH) begin : g_bad_width
    $fatal(1, "fpnew_special_encoder: OutWidth must be at least the format width");
  end

  logic          enc_sign;
  logic [E-1:0]  enc_exp;
  logic [M-1:0]  enc_man;

  always_comb begin
    enc_sign = sign_i;
    enc_exp  = '0;
    enc_man  = '0;
    case (class_i)
      CLS_INF: enc_exp = '1;
      CLS_QNAN: begin
        enc_sign       = 1'b0;
        enc_exp        = '1;
        enc_man[M-1]   = 1'b1;
      end
      CLS_SNAN: begin
        enc_sign   = 1'b0;
        enc_exp    = '1;
        enc_man[0] = 1'b1;
      end
      CLS_MAX_NORM: begin
        enc_exp = {{(E-1){1'b1}}, 1'b0};
        enc_man = '1;
      end
      CLS_MIN_NORM: enc_exp[0] = 1'b1;
      CLS_MIN_SUB:  enc_man[0] = 1'b1;
      CLS_ONE:      enc_exp = {1'b0, {(E-1){1'b1}}};
      default: ;
    endcase
  end

  // Boxing happens before stage 0 so every stage carries the full-width word.
  logic [OutWidth-1:0] enc_data;

  if (OutWidth > WIDTH) begin : g_box
    assign enc_data = {{(OutWidth-WIDTH){box_i}}, enc_sign, enc_exp, enc_man};
  end else begin : g_nobox
    logic unused_box;
    assign unused_box = box_i;
    assign enc_data   = {enc_sign, enc_exp, enc_man};
  end

`ifdef FPNEW_SPECIAL_ENC_INFO_EN
  fp_info_t info_in;

  always_comb begin
    info_in               = '0;
    info_in.is_normal     = (class_i == CLS_MAX_NORM) || (class_i == CLS_MIN_NORM) ||
                            (class_i == CLS_ONE);
    info_in.is_subnormal  = (class_i == CLS_MIN_SUB);
    info_in.is_zero       = (class_i == CLS_ZERO);
    info_in.is_inf        = (class_i == CLS_INF);
    info_in.is_nan        = (class_i == CLS_QNAN) || (class_i == CLS_SNAN);
    info_in.is_signalling = (class_i == CLS_SNAN);
    info_in.is_quiet      = (class_i == CLS_QNAN);
    info_in.is_boxed      = box_i || (OutWidth == WIDTH);
  end
`endif

  if (NumPipeRegs == 0) begin : g_comb
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, flush_i};
    assign in_ready_o  = out_ready_i;
    assign out_valid_o = in_valid_i;
    assign result_o    = enc_data;
    assign tag_o       = tag_i;
    assign busy_o      = 1'b0;
`ifdef FPNEW_SPECIAL_ENC_INFO_EN
    assign info_o      = info_in;
`endif
  end else begin : g_pipe
    logic [NumPipeRegs-1:0] valid_reg;
    logic [NumPipeRegs-1:0] stage_ready;
    logic [OutWidth-1:0]    data_reg [NumPipeRegs];
    logic [TagWidth-1:0]    tag_reg  [NumPipeRegs];
`ifdef FPNEW_SPECIAL_ENC_INFO_EN
    fp_info_t               info_reg [NumPipeRegs];
`endif

    for (genvar gi = 0; gi < NumPipeRegs; gi++) begin : g_stage
      logic                prev_valid;
      logic [OutWidth-1:0] prev_data;
      logic [TagWidth-1:0] prev_tag;
      logic                next_ready;
`ifdef FPNEW_SPECIAL_ENC_INFO_EN
      fp_info_t            prev_info;
`endif

      if (gi == 0) begin : g_first
        assign prev_valid = in_valid_i;
        assign prev_data  = enc_data;
        assign prev_tag   = tag_i;
`ifdef FPNEW_SPECIAL_ENC_INFO_EN
        assign prev_info  = info_in;
`endif
      end else begin : g_chain
        assign prev_valid = valid_reg[gi-1];
        assign prev_data  = data_reg[gi-1];
        assign prev_tag   = tag_reg[gi-1];
`ifdef FPNEW_SPECIAL_ENC_INFO_EN
        assign prev_info  = info_reg[gi-1];
`endif
      end

      if (gi == NumPipeRegs - 1) begin : g_last
        assign next_ready = out_ready_i;
      end else begin : g_inner
        assign next_ready = stage_ready[gi+1];
      end

      // A stage can take new data when it is empty or its content is leaving this cycle.
      assign stage_ready[gi] = ~valid_reg[gi] | next_ready;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          valid_reg[gi] <= 1'b0;
        end else if (flush_i) begin
          valid_reg[gi] <= 1'b0;
        end else if (stage_ready[gi]) begin
          valid_reg[gi] <= prev_valid;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          data_reg[gi] <= '0;
          tag_reg[gi]  <= '0;
`ifdef FPNEW_SPECIAL_ENC_INFO_EN
          info_reg[gi] <= '0;
`endif
        end else if (prev_valid && stage_ready[gi]) begin
          data_reg[gi] <= prev_data;
          tag_reg[gi]  <= prev_tag;
`ifdef FPNEW_SPECIAL_ENC_INFO_EN
          info_reg[gi] <= prev_info;
`endif
        end
      end
    end

    assign in_ready_o  = stage_ready[0];
    assign out_valid_o = valid_reg[NumPipeRegs-1];
    assign result_o    = data_reg[NumPipeRegs-1];
    assign tag_o       = tag_reg[NumPipeRegs-1];
    assign busy_o      = |valid_reg;
`ifdef FPNEW_SPECIAL_ENC_INFO_EN
    assign info_o      = info_reg[NumPipeRegs-1];
`endif
  end

endmodule

// File: tb/tb_fpnew_special_encoder.sv
// Bench for fpnew_special_encoder: a 2-stage FP32-in-64 instance against a queue scoreboard,
// plus a combinational FP16-in-32 instance checked every cycle against an arithmetic model.
module tb_fpnew_special_encoder;

  localparam int CLS_ZERO = 0, CLS_INF = 1, CLS_QNAN = 2, CLS_SNAN = 3;
  localparam int CLS_MAXN = 4, CLS_MINN = 5, CLS_MINS = 6, CLS_ONE = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [2:0]  cls;
  logic        sgn, box, in_valid, out_ready, flush;
  logic [3:0]  tag;
  logic        in_ready, out_valid, busy;
  logic [63:0] result;
  logic [3:0]  tag_out;

  logic [2:0]  c_cls;
  logic        c_sgn, c_box, c_in_valid, c_out_ready;
  logic [1:0]  c_tag;
  logic        c_in_ready, c_out_valid, c_busy;
  logic [31:0] c_result;
  logic [1:0]  c_tag_out;

  fpnew_special_encoder #(
    .FpFormat(0), .OutWidth(64), .NumPipeRegs(2), .TagWidth(4)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .class_i(cls), .sign_i(sgn), .box_i(box), .tag_i(tag),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush), .result_o(result),
    .tag_o(tag_out), .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
  );

  fpnew_special_encoder #(
    .FpFormat(2), .OutWidth(32), .NumPipeRegs(0), .TagWidth(2)
  ) u_comb (
    .clk_i(clk), .rst_ni(rst_n), .class_i(c_cls), .sign_i(c_sgn), .box_i(c_box), .tag_i(c_tag),
    .in_valid_i(c_in_valid), .in_ready_o(c_in_ready), .flush_i(flush), .result_o(c_result),
    .tag_o(c_tag_out), .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .busy_o(c_busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_value(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, got, want);
    end
  endtask

  function automatic logic [63:0] ones(int n);
    return (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
  endfunction

  // Value = sign*2^(W-1) + exponent*2^M + mantissa, plus the all-ones box above W bits.
  function automatic logic [63:0] ref_encode(int e_bits, int m_bits, int out_w, int c, bit s, bit bx);
    logic [63:0] e, m, v;
    bit sg;
    int w;
    w  = 1 + e_bits + m_bits;
    sg = s;
    e  = 0;
    m  = 0;
    case (c)
      CLS_INF:  e = ones(e_bits);
      CLS_QNAN: begin sg = 0; e = ones(e_bits); m = 64'd1 << (m_bits - 1); end
      CLS_SNAN: begin sg = 0; e = ones(e_bits); m = 1; end
      CLS_MAXN: begin e = ones(e_bits) - 1; m = ones(m_bits); end
      CLS_MINN: e = 1;
      CLS_MINS: m = 1;
      CLS_ONE:  e = (64'd1 << (e_bits - 1)) - 1;
      default: ;
    endcase
    v = e * (64'd1 << m_bits) + m;
    if (sg) v += 64'd1 << (w - 1);
    if (bx) v += ones(out_w) - ones(w);
    return v;
  endfunction

  typedef struct {
    logic [63:0] res;
    logic [3:0]  tg;
  } exp_t;

  exp_t        exp_q[$];
  bit          held_valid = 0;
  logic [63:0] held_res;
  logic [3:0]  held_tag;

  task automatic sb_sample();
    exp_t e;
    check_value("busy", busy, exp_q.size() != 0);
    check_value("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
    if (held_valid) begin
      check_value("stall_valid", out_valid, 1);
      check_value("stall_result", result, held_res);
      check_value("stall_tag", tag_out, held_tag);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_value("spurious_out", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_value("result", result, e.res);
        check_value("tag", tag_out, e.tg);
      end
    end
    if (flush) exp_q.delete();
    if (in_valid && in_ready && !flush) begin
      e.res = ref_encode(8, 23, 64, int'(cls), sgn, box);
      e.tg  = tag;
      exp_q.push_back(e);
    end
    held_valid = out_valid && !out_ready && !flush;
    held_res   = result;
    held_tag   = tag_out;
    check_value("c_result", c_result, ref_encode(5, 10, 32, int'(c_cls), c_sgn, c_box));
    check_value("c_tag", c_tag_out, c_tag);
    check_value("c_out_valid", c_out_valid, c_in_valid);
    check_value("c_in_ready", c_in_ready, c_out_ready);
    check_value("c_busy", c_busy, 0);
  endtask

  task automatic cycle();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 0;
    flush     = 0;
    out_ready = 1;
    repeat (4) cycle();
  endtask

  int          d_cls [8] = '{CLS_QNAN, CLS_INF, CLS_ONE, CLS_MAXN, CLS_MINS, CLS_SNAN, CLS_ONE, CLS_ONE};
  bit          d_sgn [8] = '{1, 1, 0, 0, 0, 1, 0, 0};
  bit          d_box [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  logic [63:0] d_exp [8] = '{64'h7FC00000, 64'hFF800000, 64'h3F800000, 64'h7F7FFFFF,
                             64'h00000001, 64'h7F800001, 64'hFFFFFFFF3F800000, 64'h3F800000};

  initial begin
    int next_tag;
    bit acc;
    rst_n = 0;
    cls = 0; sgn = 0; box = 0; tag = 0; in_valid = 0; out_ready = 1; flush = 0;
    c_cls = 3'd7; c_sgn = 1; c_box = 1; c_tag = 2; c_in_valid = 1; c_out_ready = 0;
    #1;
    check_value("rst_result", result, 0);
    check_value("rst_tag", tag_out, 0);
    check_value("rst_out_valid", out_valid, 0);
    check_value("rst_busy", busy, 0);
    check_value("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;

    // Single requests through an empty pipe: two-cycle latency and exact encodings.
    for (int i = 0; i < 8; i++) begin
      cls = 3'(d_cls[i]); sgn = d_sgn[i]; box = d_box[i]; tag = 4'(i); in_valid = 1;
      cycle();
      in_valid = 0;
      check_value("lat_not_early", out_valid, 0);
      cycle();
      check_value("lat_valid", out_valid, 1);
      check_value("enc_const", result, d_exp[i]);
    end
    drain();

    // Backpressure: 4 tagged requests, output held off for 3 cycles.
    out_ready = 0;
    next_tag  = 0;
    for (int i = 0; i < 3; i++) begin
      cls = 3'($urandom_range(0, 7)); sgn = 1'($urandom); box = 1'($urandom);
      tag = 4'(next_tag); in_valid = 1;
      acc = in_ready;
      cycle();
      if (acc) next_tag++;
      if (i == 1) check_value("bp_in_ready_drop", in_ready, 0);
    end
    check_value("bp_accepts", next_tag, 2);
    out_ready = 1;
    for (int i = 0; i < 20 && next_tag < 4; i++) begin
      tag = 4'(next_tag);
      acc = in_ready;
      cycle();
      if (acc) next_tag++;
    end
    check_value("bp_all_sent", next_tag, 4);
    drain();
    check_value("bp_all_out", exp_q.size(), 0);

    // Flush with a full pipe and a simultaneous input request.
    out_ready = 0;
    in_valid  = 1;
    tag = 8;  cycle();
    tag = 9;  cycle();
    flush = 1; tag = 10; cycle();
    flush = 0; in_valid = 0;
    check_value("flush_out_valid", out_valid, 0);
    check_value("flush_busy", busy, 0);
    out_ready = 1; cls = 3'(CLS_ONE); sgn = 0; box = 0; tag = 5; in_valid = 1;
    cycle();
    in_valid = 0;
    cycle();
    check_value("post_flush_valid", out_valid, 1);
    check_value("post_flush_tag", tag_out, 5);
    check_value("post_flush_result", result, 64'h3F800000);
    drain();

    // Asynchronous reset with two requests in flight.
    out_ready = 0; in_valid = 1; cls = 3'(CLS_INF); sgn = 1; box = 1;
    tag = 12; cycle();
    tag = 13; cycle();
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    check_value("arst_result", result, 0);
    check_value("arst_tag", tag_out, 0);
    check_value("arst_out_valid", out_valid, 0);
    check_value("arst_busy", busy, 0);
    exp_q.delete();
    held_valid = 0;
    cycle();
    cycle();
    rst_n = 1;
    out_ready = 1; cls = 3'(CLS_ZERO); sgn = 1; box = 0; tag = 3; in_valid = 1;
    cycle();
    in_valid = 0;
    cycle();
    check_value("post_rst_valid", out_valid, 1);
    check_value("post_rst_result", result, 64'h80000000);
    drain();

    // Randomized traffic with backpressure and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      cls         = 3'($urandom_range(0, 7));
      sgn         = 1'($urandom);
      box         = 1'($urandom);
      tag         = 4'($urandom);
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 39) == 0);
      c_cls       = 3'($urandom_range(0, 7));
      c_sgn       = 1'($urandom);
      c_box       = 1'($urandom);
      c_tag       = 2'($urandom);
      c_in_valid  = 1'($urandom);
      c_out_ready = 1'($urandom);
      cycle();
    end
    drain();
    check_value("final_queue_empty", exp_q.size(), 0);
    check_value("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
